exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 34 +++
 rtl/exc_ctrl.sv | 100 ++++++++++
 tb/tb_exc_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_pkg.sv
// CP0 register map, field positions and exception codes shared by the
// exception controller and anything that decodes its registers.
package exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EC_LO = 2;
    localparam int CAUSE_EC_HI = 6;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_BD    = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

    // The FSM state is the SR.EXL bit itself.
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } exc_state_e;

endpackage

// File: rtl/exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, interrupt and exception
// arbitration, pipeline flush request and eret return address.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC,
    parameter logic [31:0] PRID_VAL   = 32'h2022_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    exc_state_e state, state_nxt;

    logic [5:0]  im;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign exl     = (state == HANDLER);
    assign int_req = (|(hw_int & im)) & ie & ~exl;
    assign exc_req = (exc_code_in != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign handler_pc = HANDLER_PC;

    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    // eret is checked before an SR write so a same-cycle mtc0 cannot re-set EXL.
    always_comb begin
        state_nxt = state;
        if (req)
            state_nxt = HANDLER;
        else if (eret)
            state_nxt = NORMAL;
        else if (en && cp0_addr == CP0_SR)
            state_nxt = cp0_wdata[SR_EXL] ? HANDLER : NORMAL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORMAL;
            im       <= '0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            state <= state_nxt;
            ip    <= hw_int;
            if (req) begin
                bd       <= bd_in;
                exc_code <= int_req ? EXC_INT : exc_code_in;
                epc      <= bd_in ? vpc - 32'd4 : vpc;
            end else if (en) begin
                if (cp0_addr == CP0_SR) begin
                    im <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                    ie <= cp0_wdata[SR_IE];
                end
                if (cp0_addr == CP0_EPC)
                    epc <= cp0_wdata;
            end
        end
    end

    always_comb begin
        case (cp0_addr)
            CP0_SR:    cp0_rdata = sr_word;
            CP0_CAUSE: cp0_rdata = cause_word;
            CP0_EPC:   cp0_rdata = epc;
            CP0_PRID:  cp0_rdata = PRID_VAL;
            default:   cp0_rdata = 32'd0;
        endcase
    end

    assign epc_out = (en && cp0_addr == CP0_EPC) ? cp0_wdata : epc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized and directed bench for exc_ctrl against a word-level CP0 model.
module tb_exc_ctrl;

    localparam logic [31:0] PRID = 32'h2022_0007;

    logic        clk = 1'b0;
    logic        reset, en, bd_in, eret, req;
    logic [4:0]  cp0_addr, exc_code_in;
    logic [31:0] cp0_wdata, cp0_rdata, vpc, epc_out, handler_pc;
    logic [5:0]  hw_int;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc),
        .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .eret(eret), .req(req), .epc_out(epc_out), .handler_pc(handler_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state as whole architectural words
    logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;
    logic        last_req;
    logic [31:0] last_epc_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, check combinational outputs, advance model at posedge
    task automatic step(input logic rst, input logic e, input logic [4:0] a,
                        input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                        input logic [4:0] ec, input logic [5:0] hw, input logic er);
        logic        ireq, ereq, r;
        logic [31:0] exp_rd, exp_epc, n_sr, n_cause, n_epc;
        reset = rst; en = e; cp0_addr = a; cp0_wdata = wd; vpc = pc;
        bd_in = bd; exc_code_in = ec; hw_int = hw; eret = er;
        #1;
        ireq = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        ereq = (ec != 5'd0) && !m_sr[1];
        r    = ireq || ereq;
        case (a)
            5'd12:   exp_rd = m_sr;
            5'd13:   exp_rd = m_cause;
            5'd14:   exp_rd = m_epc;
            5'd15:   exp_rd = PRID;
            default: exp_rd = 32'd0;
        endcase
        exp_epc = (e && a == 5'd14) ? wd : m_epc;
        chk("req", {31'd0, req}, {31'd0, r});
        chk("rdata", cp0_rdata, exp_rd);
        chk("epc_out", epc_out, exp_epc);
        last_req = req;
        last_epc_out = epc_out;

        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        if (rst) begin
            n_sr = 0; n_cause = 0; n_epc = 0;
        end else begin
            n_cause[15:10] = hw;
            if (r) begin
                n_sr[1]       = 1'b1;
                n_cause[31]   = bd;
                n_cause[6:2]  = ireq ? 5'd0 : ec;
                n_epc         = bd ? pc - 32'd4 : pc;
            end else begin
                if (e && a == 5'd12) n_sr = wd & 32'h0000_FC03;
                if (e && a == 5'd14) n_epc = wd;
                if (er) n_sr[1] = 1'b0;
            end
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        @(negedge clk);
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a; en = 1'b0;
        #1;
        d = cp0_rdata;
    endtask

    task automatic idle();
        step(0, 0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  codes [7];
        codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
        @(negedge clk);

        // reset state
        step(1, 0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 0);
        peek(5'd12, d); chk("rst_sr", d, 32'd0);
        peek(5'd13, d); chk("rst_cause", d, 32'd0);
        peek(5'd14, d); chk("rst_epc", d, 32'd0);
        peek(5'd15, d); chk("rst_prid", d, PRID);
        chk("handler_pc", handler_pc, 32'h0000_4180);

        // interrupt taken with zero latency
        step(0, 1, 5'd12, 32'h0000_0401, 0, 0, 5'd0, 6'd0, 0);
        step(0, 0, 5'd0, 0, 32'h3010, 0, 5'd0, 6'b000001, 0);
        chk("int_req", {31'd0, last_req}, 32'd1);
        peek(5'd14, d); chk("int_epc", d, 32'h3010);
        peek(5'd13, d); chk("int_code", d & 32'h7C, 32'd0);
        peek(5'd12, d); chk("int_sr", d, 32'h0000_0403);
        step(0, 0, 5'd0, 0, 32'h3014, 0, 5'd0, 6'b000001, 0);
        chk("int_noreq", {31'd0, last_req}, 32'd0);

        // exception in a delay slot
        step(0, 0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1);
        step(0, 0, 5'd0, 0, 32'h3024, 1, 5'd12, 6'd0, 0);
        peek(5'd14, d); chk("bd_epc", d, 32'h3020);
        peek(5'd13, d); chk("bd_cause", d, 32'h8000_0030);

        // nested events are masked
        step(0, 0, 5'd0, 0, 32'h3050, 0, 5'd4, 6'h3F, 0);
        chk("mask_req", {31'd0, last_req}, 32'd0);
        peek(5'd14, d); chk("mask_epc", d, 32'h3020);
        peek(5'd13, d); chk("mask_cause", d & 32'hFFFF_03FF, 32'h8000_0030);

        // eret with same-cycle EPC write forwards it
        step(0, 1, 5'd14, 32'h3100, 0, 0, 5'd0, 6'd0, 1);
        chk("eret_fwd", last_epc_out, 32'h3100);
        peek(5'd12, d); chk("eret_sr", d, 32'h0000_0401);

        // interrupt beats a pending exception; then req beats eret and mtc0
        step(0, 0, 5'd0, 0, 32'h3200, 0, 5'd10, 6'd1, 0);
        peek(5'd13, d); chk("prio_code", d & 32'h7C, 32'd0);
        step(0, 0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1);
        step(0, 1, 5'd14, 32'hDEAD_BEEF, 32'h3300, 0, 5'd0, 6'd1, 1);
        chk("sim_req", {31'd0, last_req}, 32'd1);
        peek(5'd12, d); chk("sim_exl", d & 32'h2, 32'h2);
        peek(5'd14, d); chk("sim_epc", d, 32'h3300);

        // reset in the middle of a handler
        step(0, 1, 5'd14, 32'h3040, 0, 0, 5'd0, 6'd0, 0);
        step(1, 1, 5'd12, 32'hFFFF_FFFF, 32'h3060, 1, 5'd12, 6'h3F, 1);
        peek(5'd12, d); chk("mid_sr", d, 32'd0);
        peek(5'd13, d); chk("mid_cause", d, 32'd0);
        peek(5'd14, d); chk("mid_epc", d, 32'd0);
        peek(5'd15, d); chk("mid_prid", d, PRID);
        idle();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(2) == 0),
                 5'(10 + $urandom_range(7)),
                 $urandom,
                 {$urandom_range(32'hFFFF), 2'b00},
                 1'($urandom_range(1)),
                 codes[$urandom_range(6)],
                 ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0,
                 ($urandom_range(5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
